// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon sequence engine.
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SHOW_ON,
    SHOW_OFF,
    WAIT_IN,
    CHECK,
    WIN,
    LOSE
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Colour index to lamp/button vector; callers slice to their colour count.
  function automatic logic [15:0] onehot(input logic [3:0] idx);
    return 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/simon_seq_engine_if.sv
// Player-facing signal bundle: start/buttons in, lamps and status out.
interface simon_seq_engine_if #(
  parameter int NUM_COLORS = 4,
  parameter int LW         = 5
);
  logic                  start;
  logic [NUM_COLORS-1:0] btn;
  logic [NUM_COLORS-1:0] lamp;
  logic [LW-1:0]         level;
  logic [3:0]            miss_cnt;
  logic                  busy;
  logic                  win;
  logic                  lose;

  modport master (output start, btn, input lamp, level, miss_cnt, busy, win, lose);
  modport slave  (input start, btn, output lamp, level, miss_cnt, busy, win, lose);
endinterface

// File: rtl/simon_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the colour source.
module simon_lfsr16
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  // Shift left, new bit is the parity of the tapped positions.
  always_comb begin
    q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
  end

  // State register, reloads the seed on reset.
  always_ff @(posedge clk) begin
    if (!reset_n) q_q <= LFSR_SEED;
    else          q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/simon_seq_engine.sv
// Simon game core: grows a random colour sequence, replays it on the lamps,
// then checks the player's presses against it.
module simon_seq_engine
  import simon_pkg::*;
#(
  parameter int NUM_COLORS     = 4,
  parameter int MAX_LEN        = 16,
  parameter int BLINK_CYCLES   = 25_000_000,
  parameter int GAP_CYCLES     = 12_500_000,
  parameter int TIMEOUT_CYCLES = 250_000_000,
  parameter int STRICT         = 1
)(
  input  logic              CLOCK_50,
  input  logic              reset_n,
  simon_seq_engine_if.slave bus
);

  localparam int CW = $clog2(NUM_COLORS);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [31:0] BLINK_LAST   = BLINK_CYCLES - 1;
  localparam logic [31:0] GAP_LAST     = GAP_CYCLES - 1;
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 1;

  state_t                state_q, state_d;
  logic [NUM_COLORS-1:0] lamp_q, lamp_d;
  logic [LW-1:0]         level_q, level_d;
  logic [3:0]            miss_q, miss_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [31:0]           timer_q, timer_d;
  logic [NUM_COLORS-1:0] btn_q, btn_d;
  logic [NUM_COLORS-1:0] press_q, press_d;
  logic [CW-1:0]         mem [MAX_LEN];
  logic                  mem_we;

  logic [15:0]           lfsr;
  logic                  unused_lfsr;
  logic                  press, match, last_step, err;
  logic [LW-1:0]         idx_ext;
  logic [15:0]           oh_exp, oh_show;
  logic [CW-1:0]         show_color;

  simon_lfsr16 u_lfsr (
    .clk     (CLOCK_50),
    .reset_n (reset_n),
    .q       (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:CW];

  // Press detection and comparison of the latched press against the expected colour.
  always_comb begin
    btn_d     = bus.btn;
    press     = (btn_q == '0) && (bus.btn != '0);
    idx_ext   = LW'(idx_q);
    last_step = (idx_ext == level_q - LW'(1));
    oh_exp    = onehot(4'(mem[idx_q]));
    match     = $onehot(press_q) && (press_q == oh_exp[NUM_COLORS-1:0]);
  end

  // Next-state logic; timeouts and mismatches share one error path.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    miss_d  = miss_q;
    idx_d   = idx_q;
    timer_d = '0;
    press_d = press_q;
    mem_we  = 1'b0;
    err     = 1'b0;
    case (state_q)
      IDLE, WIN, LOSE: begin
        if (bus.start) begin
          state_d = GEN;
          level_d = '0;
          miss_d  = '0;
        end
      end
      GEN: begin
        mem_we  = 1'b1;
        level_d = level_q + LW'(1);
        idx_d   = '0;
        state_d = SHOW_ON;
      end
      SHOW_ON: begin
        if (timer_q == BLINK_LAST) state_d = SHOW_OFF;
        else                       timer_d = timer_q + 32'd1;
      end
      SHOW_OFF: begin
        if (timer_q == GAP_LAST) begin
          if (idx_ext + LW'(1) == level_q) begin
            idx_d   = '0;
            state_d = WAIT_IN;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = SHOW_ON;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      WAIT_IN: begin
        if (press) begin
          press_d = bus.btn;
          state_d = CHECK;
        end else if (timer_q == TIMEOUT_LAST) begin
          err = 1'b1;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      CHECK: begin
        if (match) begin
          if (last_step) begin
            state_d = (level_q == LW'(MAX_LEN)) ? WIN : GEN;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = WAIT_IN;
          end
        end else begin
          err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (err) begin
      if (STRICT != 0) begin
        state_d = LOSE;
      end else begin
        state_d = SHOW_ON;
        idx_d   = '0;
        if (miss_q != 4'hF) miss_d = miss_q + 4'd1;
      end
    end
  end

  // Lamp follows the next state; a freshly generated entry is bypassed from the LFSR.
  always_comb begin
    show_color = (mem_we && (LW'(idx_d) == level_q)) ? lfsr[CW-1:0] : mem[idx_d];
    oh_show    = onehot(4'(show_color));
    lamp_d     = (state_d == SHOW_ON) ? oh_show[NUM_COLORS-1:0] : '0;
  end

  // Control registers; reset overrides every other event.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lamp_q  <= '0;
      level_q <= '0;
      miss_q  <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      btn_q   <= '0;
      press_q <= '0;
    end else begin
      state_q <= state_d;
      lamp_q  <= lamp_d;
      level_q <= level_d;
      miss_q  <= miss_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      btn_q   <= btn_d;
      press_q <= press_d;
    end
  end

  // Sequence memory, appended once per GEN cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset_n && mem_we) mem[level_q[IW-1:0]] <= lfsr[CW-1:0];
  end

  assign bus.lamp     = lamp_q;
  assign bus.level    = level_q;
  assign bus.miss_cnt = miss_q;
  assign bus.busy     = (state_q == GEN) || (state_q == SHOW_ON) ||
                        (state_q == SHOW_OFF) || (state_q == CHECK);
  assign bus.win      = (state_q == WIN);
  assign bus.lose     = (state_q == LOSE);

endmodule

// File: tb/tb_simon_seq_engine.sv
// Directed bench for simon_seq_engine: one strict and one forgiving instance.
module tb_simon_seq_engine;
  localparam int NC = 4;
  localparam int ML = 3;
  localparam int LW = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_s;
  logic [3:0] btn_s;
  logic       sel;

  always #5 clk = ~clk;

  simon_seq_engine_if #(.NUM_COLORS(NC), .LW(LW)) if_s ();
  simon_seq_engine_if #(.NUM_COLORS(NC), .LW(LW)) if_l ();

  assign if_s.start = sel ? 1'b0 : start_s;
  assign if_s.btn   = sel ? 4'b0 : btn_s;
  assign if_l.start = sel ? start_s : 1'b0;
  assign if_l.btn   = sel ? btn_s : 4'b0;

  simon_seq_engine #(.NUM_COLORS(NC), .MAX_LEN(ML), .BLINK_CYCLES(2), .GAP_CYCLES(1),
                     .TIMEOUT_CYCLES(20), .STRICT(1)) u_strict (
    .CLOCK_50 (clk), .reset_n (reset_n), .bus (if_s));
  simon_seq_engine #(.NUM_COLORS(NC), .MAX_LEN(ML), .BLINK_CYCLES(2), .GAP_CYCLES(1),
                     .TIMEOUT_CYCLES(20), .STRICT(0)) u_lenient (
    .CLOCK_50 (clk), .reset_n (reset_n), .bus (if_l));

  logic [3:0]    lamp;
  logic [LW-1:0] level;
  logic [3:0]    miss;
  logic          busy, win, lose;
  assign lamp  = sel ? if_l.lamp     : if_s.lamp;
  assign level = sel ? if_l.level    : if_s.level;
  assign miss  = sel ? if_l.miss_cnt : if_s.miss_cnt;
  assign busy  = sel ? if_l.busy     : if_s.busy;
  assign win   = sel ? if_l.win      : if_s.win;
  assign lose  = sel ? if_l.lose     : if_s.lose;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1.
  logic [15:0] lfsr_m;
  always @(posedge clk) begin
    if (!reset_n) lfsr_m <= 16'hACE1;
    else          lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  int         errors = 0;
  int         checks = 0;
  logic [1:0] exp_mem [ML];
  int         cur_level = 0;

  typedef struct {
    bit         use_mem;
    bit         wrong;
    int         idx;
    logic [3:0] raw;
    bit         e_busy;
    bit         e_win;
    bit         e_lose;
    int         e_level;
    int         e_miss;
    bit         nxt_gen;
    bit         nxt_show;
  } vec_t;
  vec_t tbl [15];

  function automatic logic [3:0] oh(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    cur_level = 0;
  endtask

  // Current cycle is GEN: record the colour being appended.
  task automatic gen();
    check("gen_busy", 32'(busy), 1);
    exp_mem[cur_level] = lfsr_m[1:0];
    cur_level++;
    tick();
  endtask

  // Current cycle is the first SHOW_ON of a replay; ends in WAIT_IN.
  task automatic show();
    for (int k = 0; k < cur_level; k++) begin
      check("show_on1", 32'(lamp), 32'(oh(exp_mem[k])));
      tick();
      check("show_on2", 32'(lamp), 32'(oh(exp_mem[k])));
      tick();
      check("show_off", 32'(lamp), 0);
      tick();
    end
    check("wait_busy", 32'(busy), 0);
    check("wait_level", 32'(level), cur_level);
  endtask

  task automatic press(input logic [3:0] b);
    btn_s = b;
    tick();
    check("press_check", 32'(busy), 1);
    btn_s = 4'b0;
    tick();
  endtask

  task automatic timeout_wait();
    for (int i = 0; i < 19; i++) tick();
    check("timeout_early_busy", 32'(busy), 0);
    check("timeout_early_lose", 32'(lose), 0);
    tick();
  endtask

  task automatic run_vec(input int first, input int last);
    vec_t       v;
    logic [1:0] c;
    logic [3:0] b;
    for (int i = first; i <= last; i++) begin
      v = tbl[i];
      c = exp_mem[v.idx];
      if (v.wrong) c = c + 2'd1;
      b = v.use_mem ? oh(c) : v.raw;
      press(b);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(v.e_busy));
      check($sformatf("vec%0d_win", i), 32'(win), 32'(v.e_win));
      check($sformatf("vec%0d_lose", i), 32'(lose), 32'(v.e_lose));
      check($sformatf("vec%0d_level", i), 32'(level), v.e_level);
      check($sformatf("vec%0d_miss", i), 32'(miss), v.e_miss);
      if (!v.nxt_show) check($sformatf("vec%0d_lamp", i), 32'(lamp), 0);
      if (v.nxt_gen) begin
        gen();
        show();
      end
      if (v.nxt_show) show();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          mem wrg idx raw    bsy win los lvl mis gen shw
    tbl[0]  = '{1, 0, 0, 4'h0, 1, 0, 0, 1, 0, 1, 0};
    tbl[1]  = '{1, 0, 0, 4'h0, 0, 0, 0, 2, 0, 0, 0};
    tbl[2]  = '{1, 0, 1, 4'h0, 1, 0, 0, 2, 0, 1, 0};
    tbl[3]  = '{1, 0, 0, 4'h0, 0, 0, 0, 3, 0, 0, 0};
    tbl[4]  = '{1, 0, 1, 4'h0, 0, 0, 0, 3, 0, 0, 0};
    tbl[5]  = '{1, 0, 2, 4'h0, 0, 1, 0, 3, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 4'h0, 1, 0, 0, 1, 0, 1, 0};
    tbl[7]  = '{1, 0, 0, 4'h0, 0, 0, 0, 2, 0, 0, 0};
    tbl[8]  = '{1, 1, 1, 4'h0, 0, 0, 1, 2, 0, 0, 0};
    tbl[9]  = '{1, 0, 0, 4'h0, 1, 0, 0, 1, 0, 1, 0};
    tbl[10] = '{1, 1, 0, 4'h0, 1, 0, 0, 2, 1, 0, 1};
    tbl[11] = '{1, 0, 0, 4'h0, 0, 0, 0, 2, 1, 0, 0};
    tbl[12] = '{1, 0, 1, 4'h0, 1, 0, 0, 2, 1, 1, 0};
    tbl[13] = '{0, 0, 0, 4'h6, 1, 0, 0, 3, 2, 0, 1};
    tbl[14] = '{1, 0, 0, 4'h0, 0, 0, 0, 3, 2, 0, 0};

    sel = 1'b0; reset_n = 1'b0; start_s = 1'b0; btn_s = 4'b0;
    tick();
    tick();
    check("rst_lamp", 32'(lamp), 0);
    check("rst_level", 32'(level), 0);
    check("rst_miss", 32'(miss), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_win", 32'(win), 0);
    check("rst_lose", 32'(lose), 0);
    reset_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 0);

    // Full strict game to a win.
    do_start();
    check("gen_level0", 32'(level), 0);
    gen();
    show();
    run_vec(0, 5);

    // Restart from WIN, fail at step 2 of level 2.
    do_start();
    check("restart_win_clr", 32'(win), 0);
    gen();
    show();
    run_vec(6, 8);

    // Restart from LOSE.
    do_start();
    check("restart_lose_clr", 32'(lose), 0);
    gen();
    show();

    // Strict timeout.
    timeout_wait();
    check("timeout_lose", 32'(lose), 1);
    check("timeout_lamp", 32'(lamp), 0);

    // Non-one-hot press is an error.
    do_start();
    gen();
    show();
    press(4'b0110);
    check("multi_lose", 32'(lose), 1);
    check("multi_level", 32'(level), 1);

    // Reset in the middle of SHOW_ON.
    do_start();
    gen();
    check("midshow_lamp", 32'(lamp), 32'(oh(exp_mem[0])));
    reset_n = 1'b0;
    tick();
    check("midrst_lamp", 32'(lamp), 0);
    check("midrst_level", 32'(level), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_lose", 32'(lose), 0);
    reset_n = 1'b1;
    tick();
    check("midrst_idle", 32'(busy), 0);

    // Button held from replay into WAIT_IN must not register.
    do_start();
    gen();
    btn_s = oh(exp_mem[0]);
    show();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_no_check", 32'(busy), 0);
    end
    btn_s = 4'b0;
    tick();
    check("release_no_check", 32'(busy), 0);
    press(oh(exp_mem[0]));
    check("after_held_gen", 32'(busy), 1);
    check("after_held_level", 32'(level), 1);

    // Forgiving instance.
    sel = 1'b1;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    do_start();
    gen();
    show();
    run_vec(9, 14);
    timeout_wait();
    check("len_to_busy", 32'(busy), 1);
    check("len_to_miss", 32'(miss), 3);
    check("len_to_level", 32'(level), 3);
    check("len_to_lose", 32'(lose), 0);
    show();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
